fetch_unit: RTL

Instruction-fetch stage of the pipelined MIPS core, and the consumer of the hazard unit's stall and flush decisions. Holds the fetch PC, runs a request/acknowledge transaction with instruction memory (zero or more wait states), and drives the IF/ID pipeline register. It honours StallF and StallD, and branch redirects resolved in Decode. A one-entry hold buffer ensures a returning instruction is never lost when Decode is stalled.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem request/ack handshake,
// IF/ID pipeline register and a one-entry hold buffer for acks that arrive while Decode is stalled.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_IDLE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] target_q, target_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        adv;
  logic        redirect;
  logic [1:0]  after_issue;

  assign adv         = !StallD;
  assign redirect    = PCSrcD && adv;
  assign after_issue = StallF ? S_IDLE : S_FETCH;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    target_d    = target_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;

    // Default for an advancing Decode is a bubble; loads below override it.
    // A flush is the same update, so redirects need no separate IF/ID handling.
    if (adv) begin
      instr_d = '0;
      valid_d = 1'b0;
    end

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            req_addr_d = PCBranchD;
          end else if (adv) begin
            instr_d    = imem_rdata;
            pc4_d      = req_addr_q + 32'd4;
            valid_d    = 1'b1;
            req_addr_d = req_addr_q + 32'd4;
            state_d    = after_issue;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = req_addr_q;
            buf_valid_d = 1'b1;
            req_addr_d  = req_addr_q + 32'd4;
            state_d     = S_HOLD;
          end
        end else if (redirect) begin
          target_d = PCBranchD;
          state_d  = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          buf_valid_d = 1'b0;
          req_addr_d  = PCBranchD;
          state_d     = after_issue;
        end else if (adv) begin
          instr_d     = buf_instr_q;
          pc4_d       = buf_pc_q + 32'd4;
          valid_d     = buf_valid_q;
          buf_valid_d = 1'b0;
          state_d     = after_issue;
        end
      end
      S_IDLE: begin
        if (redirect) req_addr_d = PCBranchD;
        if (!StallF) state_d = S_FETCH;
      end
      default: begin
        if (redirect) target_d = PCBranchD;
        // A redirect coinciding with the drain ack must win over the stale target.
        if (imem_ack) begin
          req_addr_d = redirect ? PCBranchD : target_q;
          state_d    = S_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      req_addr_q  <= RESET_PC;
      buf_valid_q <= 1'b0;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      buf_valid_q <= buf_valid_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    target_q    <= target_d;
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

  assign imem_req  = !reset && ((state_q == S_FETCH) || (state_q == S_DRAIN));
  assign imem_addr = req_addr_q;
  assign InstrD    = instr_q;
  assign PCPlus4D  = pc4_q;
  assign ValidD    = valid_q;

endmodule
